// File: rtl/hyperbus_cs_ctrl.sv
// HyperBus chip-select controller: one-hot CS open/close handshake with t_RWR recovery.
// Define HYPERBUS_CSM_EN to force-close CS after T_CSM_CYCLES (t_CSM enforcement).
module hyperbus_cs_ctrl #(
  parameter int unsigned NR_CS        = 2,
  parameter int unsigned T_CSM_CYCLES = 64,
  parameter int unsigned T_RWR_CYCLES = 6
) (
  input  logic             clk270,
  input  logic             rst_ni,
  input  logic             cs_req_valid_i,
  output logic             cs_req_ready_o,
  input  logic [NR_CS-1:0] cs_sel_i,
  input  logic             cs_release_i,
  output logic [NR_CS-1:0] hyper_cs_no,
  output logic             cs_active_o,
  output logic             csm_expire_o,
  output logic             sel_err_o,
  output logic             busy_o
);

  localparam int unsigned RWR_W = (T_RWR_CYCLES > 1) ? $clog2(T_RWR_CYCLES) : 1;
  localparam logic [RWR_W-1:0] RWR_LOAD = RWR_W'(T_RWR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e           state_r, state_s;
  logic [RWR_W-1:0] rwr_cnt_r, rwr_cnt_s;
  logic [NR_CS-1:0] cs_n_s;
  logic             expire_s;
  logic             sel_err_s;
  logic             sel_ok_s;
  logic             csm_hit_s;

  function automatic logic is_onehot(input logic [NR_CS-1:0] v);
    return (v != '0) && ((v & (v - NR_CS'(1))) == '0);
  endfunction

  assign sel_ok_s = is_onehot(cs_sel_i);

`ifdef HYPERBUS_CSM_EN
  localparam int unsigned CSM_W = $clog2(T_CSM_CYCLES + 1);
  localparam logic [CSM_W-1:0] CSM_MAX = CSM_W'(T_CSM_CYCLES);

  logic [CSM_W-1:0] csm_cnt_r, csm_cnt_s;

  assign csm_hit_s = (csm_cnt_r == CSM_MAX);

  // csm_cnt starts at 1 on accept so CS is low exactly T_CSM_CYCLES cycles
  always_comb begin
    csm_cnt_s = csm_cnt_r;
    case (state_r)
      IDLE: begin
        if (cs_req_valid_i && sel_ok_s) begin
          csm_cnt_s = CSM_W'(1);
        end else begin
          csm_cnt_s = csm_cnt_r;
        end
      end
      ACTIVE: begin
        if (!cs_release_i && !csm_hit_s) begin
          csm_cnt_s = csm_cnt_r + CSM_W'(1);
        end else begin
          csm_cnt_s = csm_cnt_r;
        end
      end
      default: csm_cnt_s = csm_cnt_r;
    endcase
  end

  // t_CSM counter register
  always_ff @(posedge clk270 or negedge rst_ni) begin
    if (!rst_ni) begin
      csm_cnt_r <= '0;
    end else begin
      csm_cnt_r <= csm_cnt_s;
    end
  end
`else
  assign csm_hit_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk270 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; release takes priority over t_CSM expiry
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cs_req_valid_i && sel_ok_s) begin
          state_s = ACTIVE;
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_release_i || csm_hit_s) begin
          state_s = RECOVER;
        end else begin
          state_s = ACTIVE;
        end
      end
      RECOVER: begin
        if (rwr_cnt_r == '0) begin
          state_s = IDLE;
        end else begin
          state_s = RECOVER;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values for the registered chip selects, pulses and recovery counter
  always_comb begin
    cs_n_s    = '1;
    expire_s  = 1'b0;
    sel_err_s = 1'b0;
    rwr_cnt_s = rwr_cnt_r;
    case (state_r)
      IDLE: begin
        if (cs_req_valid_i && sel_ok_s) begin
          cs_n_s = ~cs_sel_i;
        end else if (cs_req_valid_i) begin
          sel_err_s = 1'b1;
        end else begin
          cs_n_s = '1;
        end
      end
      ACTIVE: begin
        if (cs_release_i) begin
          rwr_cnt_s = RWR_LOAD;
        end else if (csm_hit_s) begin
          expire_s  = 1'b1;
          rwr_cnt_s = RWR_LOAD;
        end else begin
          cs_n_s = hyper_cs_no;
        end
      end
      RECOVER: begin
        if (rwr_cnt_r != '0) begin
          rwr_cnt_s = rwr_cnt_r - RWR_W'(1);
        end else begin
          rwr_cnt_s = rwr_cnt_r;
        end
      end
      default: cs_n_s = '1;
    endcase
  end

  // Registered outputs; reset drives all chip selects high asynchronously
  always_ff @(posedge clk270 or negedge rst_ni) begin
    if (!rst_ni) begin
      hyper_cs_no  <= '1;
      csm_expire_o <= 1'b0;
      sel_err_o    <= 1'b0;
      rwr_cnt_r    <= '0;
    end else begin
      hyper_cs_no  <= cs_n_s;
      csm_expire_o <= expire_s;
      sel_err_o    <= sel_err_s;
      rwr_cnt_r    <= rwr_cnt_s;
    end
  end

  assign cs_req_ready_o = (state_r == IDLE);
  assign busy_o         = (state_r != IDLE);
  assign cs_active_o    = ~&hyper_cs_no;

endmodule

// File: tb/tb_hyperbus_cs_ctrl.sv
// Self-checking bench for hyperbus_cs_ctrl (NR_CS=4, T_CSM=8, T_RWR=3).
// Expected waveforms come from the transaction timing rules, honouring HYPERBUS_CSM_EN.
`timescale 1ns/1ps
module tb_hyperbus_cs_ctrl;
  localparam int NR_CS = 4;
  localparam int T_CSM = 8;
  localparam int T_RWR = 3;

  logic             clk270         = 1'b0;
  logic             rst_ni         = 1'b0;
  logic             cs_req_valid_i = 1'b0;
  logic             cs_release_i   = 1'b0;
  logic [NR_CS-1:0] cs_sel_i       = 4'b0000;
  logic             cs_req_ready_o;
  logic [NR_CS-1:0] hyper_cs_no;
  logic             cs_active_o;
  logic             csm_expire_o;
  logic             sel_err_o;
  logic             busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk270 = ~clk270;

  hyperbus_cs_ctrl #(
    .NR_CS        (NR_CS),
    .T_CSM_CYCLES (T_CSM),
    .T_RWR_CYCLES (T_RWR)
  ) dut (
    .clk270         (clk270),
    .rst_ni         (rst_ni),
    .cs_req_valid_i (cs_req_valid_i),
    .cs_req_ready_o (cs_req_ready_o),
    .cs_sel_i       (cs_sel_i),
    .cs_release_i   (cs_release_i),
    .hyper_cs_no    (hyper_cs_no),
    .cs_active_o    (cs_active_o),
    .csm_expire_o   (csm_expire_o),
    .sel_err_o      (sel_err_o),
    .busy_o         (busy_o)
  );

  // One transaction from an idle negedge. rel = edges after accept at which release
  // is sampled (0 = never). Observation j is taken after edge E+j.
  task automatic run_txn(input logic [3:0] sel, input int rel, input bit chain,
                         input logic [3:0] nsel, input string name);
    int         len;
    bit         exp_x;
    logic [3:0] e_cs;
    logic       e_act, e_rdy, e_busy, e_exp;
`ifdef HYPERBUS_CSM_EN
    if (rel == 0 || rel > T_CSM) begin
      len = T_CSM; exp_x = 1'b1;
    end else begin
      len = rel; exp_x = 1'b0;
    end
`else
    len = rel; exp_x = 1'b0;
`endif
    n_cmp++;
    if (cs_req_ready_o !== 1'b1) begin
      $display("FAIL %s ready_before_req: got %b want 1", name, cs_req_ready_o);
      n_err++;
    end
    cs_req_valid_i = 1'b1;
    cs_sel_i       = sel;
    for (int j = 0; j <= len + T_RWR; j++) begin
      @(posedge clk270);
      @(negedge clk270);
      e_cs   = (j < len) ? ~sel : 4'b1111;
      e_act  = (j < len);
      e_rdy  = (j >= len + T_RWR);
      e_busy = !e_rdy;
      e_exp  = exp_x && (j == len);
      n_cmp++;
      if ({hyper_cs_no, cs_active_o, cs_req_ready_o, busy_o, csm_expire_o, sel_err_o} !==
          {e_cs, e_act, e_rdy, e_busy, e_exp, 1'b0}) begin
        $display("FAIL %s cyc%0d: got cs=%b act=%b rdy=%b busy=%b exp=%b err=%b want cs=%b act=%b rdy=%b busy=%b exp=%b err=0",
                 name, j, hyper_cs_no, cs_active_o, cs_req_ready_o, busy_o, csm_expire_o, sel_err_o,
                 e_cs, e_act, e_rdy, e_busy, e_exp);
        n_err++;
      end
      cs_req_valid_i = 1'b0;
      cs_release_i   = (rel != 0) && (j + 1 == rel);
      if (j == len + T_RWR && chain) begin
        cs_req_valid_i = 1'b1;
        cs_sel_i       = nsel;
      end
    end
    cs_release_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk270);
    n_cmp++;
    if ({hyper_cs_no, cs_req_ready_o, busy_o, cs_active_o, csm_expire_o, sel_err_o} !== 9'b1111_1_0_0_0_0) begin
      $display("FAIL reset_hold: got cs=%b rdy=%b busy=%b act=%b exp=%b err=%b want 1111 1 0 0 0 0",
               hyper_cs_no, cs_req_ready_o, busy_o, cs_active_o, csm_expire_o, sel_err_o);
      n_err++;
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk270);
    n_cmp++;
    if ({hyper_cs_no, cs_req_ready_o, busy_o, cs_active_o, csm_expire_o, sel_err_o} !== 9'b1111_1_0_0_0_0) begin
      $display("FAIL reset_idle: got cs=%b rdy=%b busy=%b act=%b exp=%b err=%b want 1111 1 0 0 0 0",
               hyper_cs_no, cs_req_ready_o, busy_o, cs_active_o, csm_expire_o, sel_err_o);
      n_err++;
    end
  endtask

  task automatic test_async_reset();
    cs_req_valid_i = 1'b1;
    cs_sel_i       = 4'b0100;
    @(posedge clk270);
    @(negedge clk270);
    cs_req_valid_i = 1'b0;
    n_cmp++;
    if (hyper_cs_no !== 4'b1011) begin
      $display("FAIL async_rst_pre: got cs=%b want 1011", hyper_cs_no);
      n_err++;
    end
    #1 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({hyper_cs_no, busy_o, cs_req_ready_o} !== 6'b1111_0_1) begin
      $display("FAIL async_rst_no_edge: got cs=%b busy=%b rdy=%b want 1111 0 1", hyper_cs_no, busy_o, cs_req_ready_o);
      n_err++;
    end
    @(negedge clk270);
    rst_ni = 1'b1;
    @(negedge clk270);
    n_cmp++;
    if ({hyper_cs_no, busy_o, cs_req_ready_o} !== 6'b1111_0_1) begin
      $display("FAIL async_rst_after: got cs=%b busy=%b rdy=%b want 1111 0 1", hyper_cs_no, busy_o, cs_req_ready_o);
      n_err++;
    end
  endtask

  task automatic test_release();
    run_txn(4'b0100, 5, 1'b0, 4'b0000, "release5");
  endtask

  task automatic test_csm_expire();
`ifdef HYPERBUS_CSM_EN
    run_txn(4'b0001, 0, 1'b0, 4'b0000, "csm_expire");
`else
    run_txn(4'b0001, 25, 1'b0, 4'b0000, "csm_disabled_long");
`endif
  endtask

  task automatic test_release_at_expiry();
    run_txn(4'b0010, T_CSM, 1'b0, 4'b0000, "release_at_csm");
  endtask

  task automatic test_sel_err();
    logic [3:0] bad[$];
    logic [3:0] r;
    bad.push_back(4'b0110);
    bad.push_back(4'b0000);
    for (int k = 0; k < 4; k++) begin
      do r = 4'($urandom_range(0, 15)); while ($countones(r) == 1);
      bad.push_back(r);
    end
    foreach (bad[k]) begin
      cs_req_valid_i = 1'b1;
      cs_sel_i       = bad[k];
      @(posedge clk270);
      @(negedge clk270);
      cs_req_valid_i = 1'b0;
      n_cmp++;
      if ({hyper_cs_no, sel_err_o, cs_req_ready_o, busy_o, cs_active_o} !== 8'b1111_1_1_0_0) begin
        $display("FAIL sel_err_pulse sel=%b: got cs=%b err=%b rdy=%b busy=%b act=%b want 1111 1 1 0 0",
                 bad[k], hyper_cs_no, sel_err_o, cs_req_ready_o, busy_o, cs_active_o);
        n_err++;
      end
      @(posedge clk270);
      @(negedge clk270);
      n_cmp++;
      if ({hyper_cs_no, sel_err_o, busy_o} !== 6'b1111_0_0) begin
        $display("FAIL sel_err_single sel=%b: got cs=%b err=%b busy=%b want 1111 0 0",
                 bad[k], hyper_cs_no, sel_err_o, busy_o);
        n_err++;
      end
    end
  endtask

  task automatic test_back_to_back();
    run_txn(4'b1000, 3, 1'b1, 4'b0010, "b2b_first");
    run_txn(4'b0010, 4, 1'b0, 4'b0000, "b2b_second");
  endtask

  task automatic test_random();
    logic [3:0] sel, nsel;
    int         rel;
    bit         chain;
    sel = 4'b0001 << $urandom_range(0, 3);
    for (int t = 0; t < 20; t++) begin
`ifdef HYPERBUS_CSM_EN
      rel = $urandom_range(1, T_CSM + 3);
`else
      rel = $urandom_range(1, 12);
`endif
      chain = (t != 19) && ($urandom_range(0, 1) == 1);
      nsel  = 4'b0001 << $urandom_range(0, 3);
      run_txn(sel, rel, chain, nsel, $sformatf("rand%0d", t));
      if (!chain) begin
        repeat ($urandom_range(0, 2)) @(negedge clk270);
      end
      sel = nsel;
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_release();
    test_csm_expire();
    test_release_at_expiry();
    test_sel_err();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hyperbus_cs_ctrl.md
# hyperbus_cs_ctrl

Parametrised HyperBus chip-select controller for NR_CS devices on a shared bus. It replaces the fixed two-device chip-select register in the PHY. It adds hardware enforcement of the maximum CS-low time (t_CSM) and of the read-write recovery time (t_RWR) through a request/release handshake. It runs on clk270 so that chip-select edges stay aligned to the future hyper_ck_o.

## Interface
- NR_CS, default 2: number of chip selects; legal range 1..16.
- T_CSM_CYCLES, default 64: maximum number of clk270 cycles CS may stay low; must be ≥2.
- T_RWR_CYCLES, default 6: recovery cycles after CS rises; must be ≥1.
- clk270  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- cs_req_valid_i  input  1  request to open a transaction.
- cs_req_ready_o  output  1  controller accepts the request; high only in IDLE.
- cs_sel_i  input  NR_CS  one-hot device select, sampled on accept.
- cs_release_i  input  1  transaction end; closes CS.
- hyper_cs_no  output  NR_CS  active-low chip selects, registered.
- cs_active_o  output  1  high while any CS is low.
- csm_expire_o  output  1  one-cycle pulse: CS was forcibly closed at t_CSM.
- sel_err_o  output  1  one-cycle pulse: request carried a non-one-hot select.
- busy_o  output  1  high in ACTIVE or RECOVER.

## Operation
- States: IDLE, ACTIVE, RECOVER.
- **IDLE**
  - cs_req_ready_o=1.
  - On valid & ready with $onehot(cs_sel_i): latch the select, drive hyper_cs_no = ~cs_sel_i, load csm_cnt=1, go to ACTIVE.
  - On valid & ready with a non-one-hot select (zero or multiple bits): pulse sel_err_o, keep all CS high, stay in IDLE. The request counts as consumed.
- **ACTIVE**
  - If cs_release_i=1: all CS high, load rwr_cnt=T_RWR_CYCLES-1, go to RECOVER.
  - Else if csm_cnt==T_CSM_CYCLES: all CS high, pulse csm_expire_o, load rwr_cnt, go to RECOVER.
  - Else: increment csm_cnt.
  - If release and expiry coincide, release wins and csm_expire_o stays 0.
- **RECOVER**
  - Decrement rwr_cnt.
  - At rwr_cnt==0, go to IDLE.
  - cs_release_i is ignored here and in IDLE.
- Counter widths: csm_cnt is $clog2(T_CSM_CYCLES+1) bits and rwr_cnt is $clog2(T_RWR_CYCLES) bits, minimum 1. Neither counter wraps; both saturate by construction.
- Derived outputs:
  - cs_active_o = ~&hyper_cs_no.
  - busy_o = (state != IDLE).
  - cs_req_ready_o is combinational from state.
- Reset values:
  - hyper_cs_no = all ones; state IDLE.
  - cs_req_ready_o=1; cs_active_o=0; csm_expire_o=0; sel_err_o=0; busy_o=0.
- Reset mid-operation forces all CS high immediately, asynchronously.

## Timing
- Accept edge E: CS low right after E (0-cycle latency). There is no separate assert state.
- Forced close: CS stays low for exactly T_CSM_CYCLES cycles. It rises after edge E+T_CSM_CYCLES, and csm_expire_o is high for the following cycle.
- Release sampled at edge R: CS high after R. cs_req_ready_o stays low for T_RWR_CYCLES cycles, then goes high.
- Minimum CS-high time between back-to-back transactions is T_RWR_CYCLES+1 cycles.
- cs_req_valid_i must be held until accepted. cs_sel_i is only sampled on accept.
- Upstream must assert cs_release_i for at least one clk270 edge. A multi-cycle release is harmless.
- Inputs are generated in the clk0 domain of the same source clock. Paths are timed as same-clock, 3/4-period.

## Configuration
- HYPERBUS_CSM_EN defined:
  - t_CSM enforcement as described above.
- HYPERBUS_CSM_EN not defined:
  - csm_cnt and its comparator are removed.
  - csm_expire_o is tied to 0.
  - ACTIVE exits only on cs_release_i.
  - T_CSM_CYCLES is ignored.

## Test plan
- Use NR_CS=4, T_CSM_CYCLES=8, T_RWR_CYCLES=3.
- Reset released, no traffic -> hyper_cs_no=4'b1111, cs_req_ready_o=1, busy_o=0. Assert rst_ni low while CS[2] is low -> hyper_cs_no=4'b1111 without a clock edge.
- Request cs_sel_i=4'b0100, release 5 cycles after accept -> hyper_cs_no=4'b1011 for 5 cycles. Then ready stays low for 3 cycles, and CS is high for at least 4 cycles before the next accept.
- Request cs_sel_i=4'b0001, no release (HYPERBUS_CSM_EN defined) -> CS[0] low for exactly 8 cycles, then a one-cycle csm_expire_o, then 3 recovery cycles.
- Same stimulus with the macro undefined -> CS[0] stays low for 20+ cycles and csm_expire_o is never asserted.
- Release coinciding with csm_cnt==8 -> CS rises and csm_expire_o stays 0.
- Request with cs_sel_i=4'b0110, then with 4'b0000 -> sel_err_o pulses once per request, all CS stay high, and the state remains IDLE.
- Back-to-back requests with valid held high on {4'b1000, 4'b0010} -> second CS falls exactly T_RWR_CYCLES+1 cycles after the first rises, and no two CS bits are ever low together.
